// File: rtl/wb_commit_ctrl.sv
// Writeback/commit sequencer: picks the GPR writeback value, drives GPR/CSR write ports, runs the ecall trap.
// Latency: every output except in_ready is registered and appears one cycle after the handshake; ecall holds the block for 3 cycles.
// Backpressure: in_ready is high only in IDLE, so an ecall stalls upstream for 2 cycles and normal ops commit one per cycle.
module wb_commit_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11,
  parameter int unsigned CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pc,
  input  logic [31:0]      dnpc,
  input  logic [2:0]       rdregsrc,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mdata,
  input  logic [31:0]      snpc,
  input  logic             cmp_result,
  input  logic [31:0]      csr_rdata,
  input  logic [11:0]      csraddr,
  input  logic             csr_we,
  input  logic             ecall,
  input  logic [4:0]       rd,
  input  logic [31:0]      mtvec,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             csr_wen,
  output logic [11:0]      csr_waddr,
  output logic [31:0]      csr_wdata,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_dnpc,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRAP_EPC   = 2'd1,
    TRAP_CAUSE = 2'd2
  } state_t;

  localparam logic [2:0]       SRC_ALU  = 3'd1;
  localparam logic [2:0]       SRC_MEM  = 3'd2;
  localparam logic [2:0]       SRC_SNPC = 3'd3;
  localparam logic [2:0]       SRC_CSR  = 3'd4;
  localparam logic [2:0]       SRC_CMP  = 3'd5;
  localparam logic [11:0]      CSR_MEPC   = 12'h341;
  localparam logic [11:0]      CSR_MCAUSE = 12'h342;
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;

  state_t      state;
  logic [31:0] trap_pc;
  logic [31:0] trap_vec;
  logic        hs;
  logic        wb_en;
  logic [31:0] wb_data;

  // Accept only when no trap sequence is in flight; depends on state alone.
  assign in_ready = (state == IDLE);
  assign hs       = in_valid & in_ready;

  // Writeback source select; encodings 0, 6 and 7 mean no GPR write.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = 32'd0;
    case (rdregsrc)
      SRC_ALU:  begin wb_en = 1'b1; wb_data = alu_result;            end
      SRC_MEM:  begin wb_en = 1'b1; wb_data = mdata;                 end
      SRC_SNPC: begin wb_en = 1'b1; wb_data = snpc;                  end
      SRC_CSR:  begin wb_en = 1'b1; wb_data = csr_rdata;             end
      SRC_CMP:  begin wb_en = 1'b1; wb_data = {31'd0, cmp_result};   end
      default:  begin wb_en = 1'b0; wb_data = 32'd0;                 end
    endcase
  end

  // Sequencer: strobes default low each cycle, data outputs hold unless a new write/commit loads them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      trap_pc        <= 32'd0;
      trap_vec       <= 32'd0;
      rf_we          <= 1'b0;
      rf_waddr       <= 5'd0;
      rf_wdata       <= 32'd0;
      csr_wen        <= 1'b0;
      csr_waddr      <= 12'd0;
      csr_wdata      <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      commit_valid   <= 1'b0;
      commit_pc      <= 32'd0;
      commit_dnpc    <= 32'd0;
      retire_cnt     <= '0;
    end else begin
      rf_we          <= 1'b0;
      csr_wen        <= 1'b0;
      redirect_valid <= 1'b0;
      commit_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            if (ecall) begin
              // First trap beat: save pc to mepc; mtvec is frozen here so later changes cannot move the redirect.
              state     <= TRAP_EPC;
              trap_pc   <= pc;
              trap_vec  <= mtvec;
              csr_wen   <= 1'b1;
              csr_waddr <= CSR_MEPC;
              csr_wdata <= pc;
            end else begin
              rf_we        <= wb_en && (rd != 5'd0);
              rf_waddr     <= rd;
              rf_wdata     <= wb_data;
              csr_wen      <= csr_we;
              csr_waddr    <= csraddr;
              csr_wdata    <= alu_result;
              commit_valid <= 1'b1;
              commit_pc    <= pc;
              commit_dnpc  <= dnpc;
              retire_cnt   <= retire_cnt + CNT_ONE;
            end
          end
        end
        TRAP_EPC: begin
          // Second trap beat: mcause write, redirect to the handler and retire the ecall together.
          state          <= TRAP_CAUSE;
          csr_wen        <= 1'b1;
          csr_waddr      <= CSR_MCAUSE;
          csr_wdata      <= MCAUSE_ECALL;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_vec;
          commit_valid   <= 1'b1;
          commit_pc      <= trap_pc;
          commit_dnpc    <= trap_vec;
          retire_cnt     <= retire_cnt + CNT_ONE;
        end
        TRAP_CAUSE: begin
          // Bubble cycle while the redirect takes effect upstream.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Randomized scoreboard bench for wb_commit_ctrl with a small retire counter so wrap is reachable.
// Expected write/commit/redirect events are queued with the cycle they must appear in.
// A negedge monitor pops and compares them, and flags missing or unexpected strobes.
module tb_wb_commit_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      pc = '0, dnpc = '0, alu_result = '0, mdata = '0, snpc = '0, csr_rdata = '0, mtvec = '0;
  logic [2:0]       rdregsrc = '0;
  logic             cmp_result = 1'b0, csr_we = 1'b0, ecall = 1'b0;
  logic [11:0]      csraddr = '0;
  logic [4:0]       rd = '0;
  logic             rf_we, csr_wen, redirect_valid, commit_valid;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata, csr_wdata, redirect_pc, commit_pc, commit_dnpc;
  logic [11:0]      csr_waddr;
  logic [CNT_W-1:0] retire_cnt;

  wb_commit_ctrl #(.MCAUSE_ECALL(32'd11), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .dnpc(dnpc), .rdregsrc(rdregsrc), .alu_result(alu_result), .mdata(mdata),
    .snpc(snpc), .cmp_result(cmp_result), .csr_rdata(csr_rdata), .csraddr(csraddr),
    .csr_we(csr_we), .ecall(ecall), .rd(rd), .mtvec(mtvec),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_dnpc(commit_dnpc),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc, dnpc, alu, mdata, snpc, csr_rdata, mtvec;
    logic [2:0]  src;
    logic        cmp, csr_we, ecall;
    logic [11:0] csraddr;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;

  // Channels: 0 GPR write, 1 CSR write, 2 commit, 3 redirect.
  ev_t   evq[4][$];
  string ch_name[4] = '{"rf", "csr", "commit", "redirect"};
  int    checks = 0;
  int    failures = 0;
  int    model_retired = 0;
  int    busy_lo = -10;
  int    busy_hi = -10;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] x);
    ev_t e;
    e.cyc = c; e.a = a; e.b = b; e.c = x;
    evq[ch].push_back(e);
  endtask

  // Reference model: what the instruction must produce, from the architectural rules.
  task automatic expect_instr(input instr_t t, input int h);
    logic        gpr;
    logic [31:0] val;
    if (t.ecall) begin
      model_retired++;
      push(1, h,     32'h341, t.pc, 32'd0);
      push(1, h + 1, 32'h342, 32'd11, 32'd0);
      push(2, h + 1, t.pc, t.mtvec, 32'(model_retired % 16));
      push(3, h + 1, t.mtvec, 32'd0, 32'd0);
      busy_lo = h;
      busy_hi = h + 1;
    end else begin
      gpr = 1'b1;
      case (t.src)
        3'd1:    val = t.alu;
        3'd2:    val = t.mdata;
        3'd3:    val = t.snpc;
        3'd4:    val = t.csr_rdata;
        3'd5:    val = {31'd0, t.cmp};
        default: begin gpr = 1'b0; val = 32'd0; end
      endcase
      if (gpr && t.rd != 5'd0) push(0, h, 32'(t.rd), val, 32'd0);
      if (t.csr_we) push(1, h, 32'(t.csraddr), t.alu, 32'd0);
      model_retired++;
      push(2, h, t.pc, t.dnpc, 32'(model_retired % 16));
    end
  endtask

  task automatic check_ch(input int ch, input logic strobe, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ev_t e;
    while (evq[ch].size() > 0 && evq[ch][0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL %s_missing: got no strobe, expected one at cycle %0d", ch_name[ch], evq[ch][0].cyc);
      void'(evq[ch].pop_front());
    end
    if (strobe) begin
      if (evq[ch].size() > 0 && evq[ch][0].cyc == cyc) begin
        e = evq[ch].pop_front();
        chk({ch_name[ch], "_a"}, a, e.a);
        chk({ch_name[ch], "_b"}, b, e.b);
        chk({ch_name[ch], "_c"}, c, e.c);
      end else begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected: got strobe at cycle %0d, expected none", ch_name[ch], cyc);
      end
    end
  endtask

  // Monitor: compares every presented strobe against the scoreboard, and in_ready against the trap window.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      chk("in_ready", {31'd0, in_ready}, (cyc >= busy_lo && cyc <= busy_hi) ? 32'd0 : 32'd1);
      check_ch(0, rf_we, 32'(rf_waddr), rf_wdata, 32'd0);
      check_ch(1, csr_wen, 32'(csr_waddr), csr_wdata, 32'd0);
      check_ch(2, commit_valid, commit_pc, commit_dnpc, 32'(retire_cnt));
      check_ch(3, redirect_valid, redirect_pc, 32'd0, 32'd0);
    end
  end

  function automatic instr_t rand_instr();
    instr_t t;
    t.pc        = $urandom();
    t.dnpc      = $urandom();
    t.alu       = $urandom();
    t.mdata     = $urandom();
    t.snpc      = $urandom();
    t.csr_rdata = $urandom();
    t.mtvec     = $urandom();
    t.src       = 3'($urandom_range(0, 7));
    t.cmp       = 1'($urandom());
    t.csr_we    = 1'($urandom());
    t.ecall     = ($urandom_range(0, 7) == 0);
    t.csraddr   = 12'($urandom());
    t.rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
    return t;
  endfunction

  task automatic apply(input instr_t t);
    pc = t.pc; dnpc = t.dnpc; alu_result = t.alu; mdata = t.mdata; snpc = t.snpc;
    csr_rdata = t.csr_rdata; mtvec = t.mtvec; rdregsrc = t.src; cmp_result = t.cmp;
    csr_we = t.csr_we; ecall = t.ecall; csraddr = t.csraddr; rd = t.rd;
  endtask

  // Present one instruction, hold it until accepted, return the cycle its outputs must appear in.
  task automatic drive(input instr_t t, output int h);
    int waits;
    waits = 0;
    h = -1;
    apply(t);
    in_valid = 1'b1;
    while (h < 0 && waits < 8) begin
      @(negedge clk);
      if (in_ready === 1'b1) h = cyc + 1;
      else waits++;
    end
    if (h < 0) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: got in_ready low for %0d cycles, expected acceptance", waits);
      in_valid = 1'b0;
      return;
    end
    expect_instr(t, h);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      apply(rand_instr());
      @(posedge clk);
      #1;
    end
  endtask

  // Async reset from the current point in time; outputs must clear with no clock edge.
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_strobes"}, {28'd0, rf_we, csr_wen, redirect_valid, commit_valid}, 32'd0);
    chk({tag, "_cnt"}, 32'(retire_cnt), 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    foreach (evq[i]) evq[i].delete();
    model_retired = 0;
    busy_lo = -10;
    busy_hi = -10;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic instr_t plain(input logic [2:0] src, input logic [4:0] r);
    instr_t t;
    t = rand_instr();
    t.ecall = 1'b0;
    t.csr_we = 1'b0;
    t.src = src;
    t.rd = r;
    return t;
  endfunction

  initial begin
    instr_t t;
    int h1, h2;

    #2;
    chk("reset_strobes", {28'd0, rf_we, csr_wen, redirect_valid, commit_valid}, 32'd0);
    chk("reset_cnt", 32'(retire_cnt), 32'd0);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset_data", rf_wdata | csr_wdata | redirect_pc | commit_pc | commit_dnpc | 32'(rf_waddr) | 32'(csr_waddr), 32'd0);
    mon_en = 1'b1;

    // Back-to-back ALU writes.
    t = plain(3'd1, 5'd5); t.alu = 32'h1234; drive(t, h1);
    t = plain(3'd1, 5'd6); t.alu = 32'h5678; drive(t, h2);
    chk("b2b_gap", 32'(h2 - h1), 32'd1);
    chk("b2b_retire", 32'(retire_cnt), 32'd2);

    // Writeback mux corners.
    t = plain(3'd5, 5'd3); t.cmp = 1'b1; drive(t, h1);
    t = plain(3'd3, 5'd4); t.snpc = 32'h8000_0008; drive(t, h1);
    t = plain(3'd2, 5'd0); drive(t, h1);
    idle(1);

    // ecall with mtvec moving right after the handshake, follow-on instruction held.
    t = plain(3'd1, 5'd8); t.ecall = 1'b1; t.pc = 32'h8000_0100; t.mtvec = 32'h8000_0400; drive(t, h1);
    t = plain(3'd1, 5'd9); t.mtvec = 32'd0; drive(t, h2);
    chk("ecall_occupancy", 32'(h2 - h1), 32'd3);

    // csrrw: old CSR value to rd, new value to CSR in the same cycle.
    t = plain(3'd4, 5'd7); t.csr_we = 1'b1; t.csraddr = 12'h305; t.alu = 32'h8000_0400; t.csr_rdata = 32'hAA;
    drive(t, h1);
    idle(2);

    // Reset with a GPR write strobe pending.
    t = plain(3'd1, 5'd9); drive(t, h1);
    reset_pulse("rst_midrun");
    idle(2);

    // Reset during the trap: mepc written, then no mcause, redirect or commit.
    t = plain(3'd0, 5'd1); t.ecall = 1'b1; drive(t, h1);
    @(negedge clk);
    #1;
    reset_pulse("rst_midtrap");
    idle(3);

    // Counter wrap: 16 commits return the 4-bit counter to zero.
    for (int i = 0; i < 16; i++) begin
      t = plain(3'($urandom_range(0, 7)), 5'($urandom())); drive(t, h1);
    end
    chk("wrap_cnt", 32'(retire_cnt), 32'd0);

    // Randomized traffic with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      drive(rand_instr(), h1);
    end

    idle(6);
    for (int ch = 0; ch < 4; ch++) chk({"drain_", ch_name[ch]}, 32'(evq[ch].size()), 32'd0);
    chk("final_cnt", 32'(retire_cnt), 32'(model_retired % 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit_ctrl.md
Name: wb_commit_ctrl

Overview:
Writeback/commit sequencer behind the M->W stage bus. It consumes one instruction per valid/ready handshake and selects the register-file writeback value. It drives GPR and CSR write ports, runs the two-cycle ecall trap sequence (mepc, then mcause, then redirect), and reports commits and the retired-instruction count to the simulator/difftest side.

Parameters:
MCAUSE_ECALL, 32'd11, value written to mcause on ecall
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset; asserted when 0
in_valid  in  1  stage bus has an instruction (m_valid of W stage bus)
in_ready  out  1  block can accept; 1 only in IDLE
pc  in  32  instruction pc
dnpc  in  32  next pc of instruction
rdregsrc  in  3  writeback select: 0 none, 1 ALU, 2 mem, 3 snpc, 4 csr, 5 cmp; 6 and 7 treated as none
alu_result  in  32  ALU result
mdata  in  32  load data
snpc  in  32  pc+4
cmp_result  in  1  compare result for slt/sltu
csr_rdata  in  32  CSR read value (old value for csrrw/csrrs)
csraddr  in  12  CSR write target
csr_we  in  1  instruction writes CSR (data = alu_result)
ecall  in  1  instruction is ecall
rd  in  5  destination register
mtvec  in  32  current trap vector
rf_we  out  1  GPR write strobe
rf_waddr  out  5  GPR write address
rf_wdata  out  32  GPR write data
csr_wen  out  1  CSR write strobe
csr_waddr  out  12  CSR write address
csr_wdata  out  32  CSR write data
redirect_valid  out  1  one-cycle pc redirect pulse
redirect_pc  out  32  redirect target
commit_valid  out  1  one-cycle commit pulse
commit_pc  out  32  committed pc
commit_dnpc  out  32  committed next pc (mtvec for ecall)
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All strobes (rf_we, csr_wen, redirect_valid, commit_valid) are 0. All address/data outputs are 0. retire_cnt=0. in_ready=1 once reset deasserts.
- All outputs except in_ready are registered. in_ready = (state==IDLE), combinational from state only.
- States: IDLE, TRAP_EPC, TRAP_CAUSE.
- IDLE, handshake (in_valid & in_ready) with ecall=0. Next cycle, for exactly one cycle:
  - rf_we=1 iff rdregsrc in {1..5} and rd!=0.
  - rf_waddr=rd.
  - rf_wdata = alu_result / mdata / snpc / csr_rdata / {31'b0,cmp_result} for rdregsrc 1..5.
  - csr_wen=csr_we, csr_waddr=csraddr, csr_wdata=alu_result.
  - commit_valid=1, commit_pc=pc, commit_dnpc=dnpc.
  - retire_cnt increments.
  - State stays IDLE, so back-to-back handshakes are allowed: one commit per cycle.
- IDLE, handshake with ecall=1:
  - Capture pc and mtvec; go to TRAP_EPC. GPR and CSR fields of the ecall are ignored.
  - Next cycle: csr_wen=1, csr_waddr=12'h341, csr_wdata=captured pc. No commit this cycle.
- TRAP_EPC: go to TRAP_CAUSE. Next cycle:
  - csr_wen=1, csr_waddr=12'h342, csr_wdata=MCAUSE_ECALL.
  - redirect_valid=1, redirect_pc=captured mtvec.
  - commit_valid=1, commit_pc=captured pc, commit_dnpc=captured mtvec.
  - retire_cnt increments.
- TRAP_CAUSE: go to IDLE unconditionally. Total ecall occupancy: 3 cycles, in_ready low for 2.
- No handshake: all strobes 0 next cycle. Data outputs hold their last values.
- Stage inputs are sampled only on handshake. Changes while in_ready=0 are ignored, and the upstream holds them per the valid/ready rule.
- retire_cnt wraps modulo 2^CNT_W with no flag.
- Reset mid-trap: aborts immediately. No further CSR writes or redirect, state=IDLE.
- mtvec is sampled at the ecall handshake; later changes do not alter redirect_pc.

Test Plan:
- Reset, then rst=1: in_ready=1, all strobes 0, retire_cnt=0. Assert rst=0 mid-run with a pending strobe -> outputs clear without a clock edge.
- Back-to-back ALU ops: rdregsrc=1, rd=5, alu_result=0x1234 then rd=6, alu_result=0x5678, on consecutive cycles -> rf_we pulses on two consecutive cycles, (5,0x1234) then (6,0x5678), and retire_cnt=2.
- Mux coverage:
  - rdregsrc=5, cmp_result=1 -> rf_wdata=0x1.
  - rdregsrc=3, snpc=0x80000008 -> rf_wdata=0x80000008.
  - rd=0 with rdregsrc=2 -> rf_we=0 but commit_valid=1.
- ecall: pc=0x80000100, mtvec=0x80000400 (mtvec changed to 0 the next cycle) ->
  - cycle+1: csr write 0x341=0x80000100.
  - cycle+2: csr write 0x342=11, redirect_pc=0x80000400, commit_dnpc=0x80000400.
  - in_ready=0 for two cycles; a held follow-on instruction is accepted on cycle+3.
- csrrw: csr_we=1, csraddr=0x305, alu_result=0x80000400, rdregsrc=4, csr_rdata=0xAA, rd=7 -> same cycle rf_wdata=0xAA and csr_wdata=0x80000400 to 0x305.
- Counter wrap with CNT_W=4: 16 commits -> retire_cnt returns to 0.
